// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Provides:
//   - R-type funct codes for every supported operation
//   - writeback mux select encodings (result_sel_t)
//   - sequencer FSM state encoding (state_t)
//   - decoded-op record (decode_t) used between the decoder and the FSM
package alu_ctrl_pkg;

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_SHT = 2'd1,
        SEL_HI  = 2'd2,
        SEL_LO  = 2'd3
    } result_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_DIV_RUN
    } state_t;

    typedef struct packed {
        logic        legal;
        logic        is_mul;
        logic        is_div;
        result_sel_t sel;
    } decode_t;

endpackage

// File: rtl/multicycle_counter.sv
// Loadable up-counter shared by the MULTU and DIVU sequences.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (count -> 0)
//   load        - sets count to 1 (first RUN cycle)
//   enable      - advance count by one
//   target      - RUN length N for the active operation
//   count       - current RUN cycle number (1..N while running)
//   start_win   - count within 1..START_CYCLES
//   done        - count has reached target
module multicycle_counter #(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned START_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             start_win,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign start_win = (count != '0) && (count <= CNT_W'(START_CYCLES));
    assign done      = (count == target);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control stage: decodes the R-type funct field into unit controls and
// sequences multicycle MULTU/DIVU, stalling issue until HI/LO is written.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   op_valid    - funct presented for issue
//   funct       - R-type funct code
//   op_ready    - op can be accepted this cycle
//   alu_ctrl    - registered funct (0 after an illegal op)
//   result_sel  - writeback mux select (ALU/SHT/HI/LO)
//   mul_start   - multiplier start, first START_CYCLES cycles of a MULTU
//   div_start   - divider start, first START_CYCLES cycles of a DIVU
//   hilo_we     - one-cycle HI/LO write strobe on the last RUN cycle
//   hilo_src    - HI/LO source: 0 multiplier, 1 divider
//   busy        - multicycle operation in flight
//   illegal     - one-cycle pulse after accepting an unsupported funct
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W      = 6,
    parameter int unsigned MUL_CYCLES   = 32,
    parameter int unsigned DIV_CYCLES   = 32,
    parameter int unsigned START_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [FUNCT_W-1:0] funct,
    output logic               op_ready,
    output logic [FUNCT_W-1:0] alu_ctrl,
    output logic [1:0]         result_sel,
    output logic               mul_start,
    output logic               div_start,
    output logic               hilo_we,
    output logic               hilo_src,
    output logic               busy,
    output logic               illegal
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t           state, state_nxt;
    decode_t          dec;
    logic             accept;
    logic             cnt_load, cnt_en, start_win, done;
    logic [CNT_W-1:0] count, target;

    assign op_ready = rst_n && (state == ST_IDLE);
    assign accept   = op_valid && op_ready;

    always_comb begin
        dec = '{legal: 1'b1, is_mul: 1'b0, is_div: 1'b0, sel: SEL_ALU};
        case (funct)
            FUNCT_W'(F_AND), FUNCT_W'(F_OR), FUNCT_W'(F_ADD),
            FUNCT_W'(F_SUB), FUNCT_W'(F_SLT): dec.sel    = SEL_ALU;
            FUNCT_W'(F_SRL):                  dec.sel    = SEL_SHT;
            FUNCT_W'(F_MFHI):                 dec.sel    = SEL_HI;
            FUNCT_W'(F_MFLO):                 dec.sel    = SEL_LO;
            FUNCT_W'(F_MULTU):                dec.is_mul = 1'b1;
            FUNCT_W'(F_DIVU):                 dec.is_div = 1'b1;
            default:                          dec.legal  = 1'b0;
        endcase
    end

    // Counter stops at the target, so it never exceeds MAX_CYCLES.
    assign cnt_load = accept && (dec.is_mul || dec.is_div);
    assign cnt_en   = (state != ST_IDLE) && (count < target);
    assign target   = (state == ST_DIV_RUN) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    multicycle_counter #(
        .CNT_W        (CNT_W),
        .START_CYCLES (START_CYCLES)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .enable    (cnt_en),
        .target    (target),
        .count     (count),
        .start_win (start_win),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && dec.is_mul) begin
                    state_nxt = ST_MUL_RUN;
                end else if (accept && dec.is_div) begin
                    state_nxt = ST_DIV_RUN;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        mul_start = (state == ST_MUL_RUN) && start_win;
        div_start = (state == ST_DIV_RUN) && start_win;
        hilo_we   = busy && done;
    end

    // Illegal ops and MULTU/DIVU leave the writeback mux on the ALU path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_ctrl   <= '0;
            result_sel <= '0;
            illegal    <= 1'b0;
            hilo_src   <= 1'b0;
        end else begin
            illegal <= accept && !dec.legal;
            if (accept) begin
                alu_ctrl   <= dec.legal ? funct : '0;
                result_sel <= dec.sel;
                if (dec.is_mul || dec.is_div) begin
                    hilo_src <= dec.is_div;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    typedef struct packed {
        logic       rdy;
        logic [5:0] ctrl;
        logic [1:0] sel;
        logic       ms;
        logic       ds;
        logic       we;
        logic       src;
        logic       busy;
        logic       ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic [5:0] funct;

    logic [1:0]      rdy, ms, ds, we, src, bsy, ill;
    logic [1:0][5:0] ctrl;
    logic [1:0][1:0] sel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: per instance, parameters plus the cycle number of the
    // last MULTU/DIVU acceptance; RUN outputs follow from the cycle offset.
    int         p_mul [2] = '{32, 32};
    int         p_div [2] = '{32, 5};
    int         p_st  [2] = '{2, 1};
    int         m_kind[2] = '{0, 0};
    int         m_t0  [2] = '{0, 0};
    logic [5:0] m_ctrl[2];
    logic [1:0] m_sel [2];
    logic       m_ill [2];
    logic       m_src [2];

    alu_op_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
        .op_ready(rdy[0]), .alu_ctrl(ctrl[0]), .result_sel(sel[0]),
        .mul_start(ms[0]), .div_start(ds[0]), .hilo_we(we[0]),
        .hilo_src(src[0]), .busy(bsy[0]), .illegal(ill[0])
    );

    alu_op_sequencer #(
        .FUNCT_W(6), .MUL_CYCLES(32), .DIV_CYCLES(5), .START_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
        .op_ready(rdy[1]), .alu_ctrl(ctrl[1]), .result_sel(sel[1]),
        .mul_start(ms[1]), .div_start(ds[1]), .hilo_we(we[1]),
        .hilo_src(src[1]), .busy(bsy[1]), .illegal(ill[1])
    );

    always #5 clk = ~clk;

    function automatic obs_t expect_of(int d);
        obs_t e;
        int   n, k;
        logic inrun;
        n      = (m_kind[d] == 2) ? p_div[d] : p_mul[d];
        k      = cyc - m_t0[d];
        inrun  = (m_kind[d] != 0) && (k >= 1) && (k <= n);
        e.rdy  = rst_n && !inrun;
        e.ctrl = m_ctrl[d];
        e.sel  = m_sel[d];
        e.ms   = inrun && (m_kind[d] == 1) && (k <= p_st[d]);
        e.ds   = inrun && (m_kind[d] == 2) && (k <= p_st[d]);
        e.we   = inrun && (k == n);
        e.src  = m_src[d];
        e.busy = inrun;
        e.ill  = m_ill[d];
        return e;
    endfunction

    function automatic obs_t observe(int d);
        obs_t o;
        o.rdy  = rdy[d];
        o.ctrl = ctrl[d];
        o.sel  = sel[d];
        o.ms   = ms[d];
        o.ds   = ds[d];
        o.we   = we[d];
        o.src  = src[d];
        o.busy = bsy[d];
        o.ill  = ill[d];
        return o;
    endfunction

    function automatic void model_edge(int d);
        obs_t       e;
        logic       legal;
        logic [1:0] s;
        int         kind;
        e = expect_of(d);
        if (!rst_n) begin
            m_kind[d] = 0;
            m_ctrl[d] = '0;
            m_sel[d]  = '0;
            m_ill[d]  = 1'b0;
            m_src[d]  = 1'b0;
        end else begin
            m_ill[d] = 1'b0;
            if (op_valid && e.rdy) begin
                legal = 1'b1;
                s     = 2'd0;
                kind  = 0;
                case (funct)
                    6'd36, 6'd37, 6'd32, 6'd34, 6'd42: s = 2'd0;
                    6'd2:  s = 2'd1;
                    6'd16: s = 2'd2;
                    6'd18: s = 2'd3;
                    6'd25: kind = 1;
                    6'd27: kind = 2;
                    default: legal = 1'b0;
                endcase
                m_ctrl[d] = legal ? funct : 6'd0;
                m_sel[d]  = legal ? s : 2'd0;
                m_ill[d]  = !legal;
                if (kind != 0) begin
                    m_kind[d] = kind;
                    m_t0[d]   = cyc;
                    m_src[d]  = (kind == 2);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL reset_state dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
        end
        checks++;
        if (rdy !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready_low got=%b exp=00", rdy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=11", rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [3] = '{6'd32, 6'd36, 6'd2};
        logic [1:0] es  [3] = '{2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1;
            funct    = seq[i];
            checks++;
            if (rdy !== 2'b11) begin
                failures++;
                $display("FAIL b2b_ready i=%0d got=%b exp=11", i, rdy);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL b2b_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
            checks++;
            if (ctrl[0] !== seq[i] || sel[0] !== es[i]) begin
                failures++;
                $display("FAIL b2b_ctrl i=%0d got=%0d/%0d exp=%0d/%0d", i, ctrl[0], sel[0], seq[i], es[i]);
            end
        end
        op_valid = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        int nb = 0, nms = 0, we_at = 0, we_src = -1, ready_at = 0, ms_first = 0;
        op_valid = 1'b1;
        funct    = 6'd25;
        tick();
        op_valid = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL multu_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
            if (bsy[0]) nb++;
            if (ms[0]) begin
                nms++;
                if (ms_first == 0) ms_first = i;
            end
            if (we[0]) begin
                we_at  = i;
                we_src = int'(src[0]);
            end
            if (rdy[0] && ready_at == 0) ready_at = i;
            tick();
        end
        checks++;
        if (nb != 32 || nms != 2 || ms_first != 1) begin
            failures++;
            $display("FAIL multu_span got busy=%0d start=%0d@%0d exp busy=32 start=2@1", nb, nms, ms_first);
        end
        checks++;
        if (we_at != 32 || we_src != 0 || ready_at != 33) begin
            failures++;
            $display("FAIL multu_done got we@%0d src=%0d ready@%0d exp we@32 src=0 ready@33", we_at, we_src, ready_at);
        end
    endtask

    task automatic test_divu();
        int nds = 0, ds_first = 0, we_at = 0, we_src = -1, nb = 0;
        logic busy6 = 1'b1;
        op_valid = 1'b1;
        funct    = 6'd27;
        tick();
        op_valid = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL divu_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
            if (ds[1]) begin
                nds++;
                if (ds_first == 0) ds_first = i;
            end
            if (we[1]) begin
                we_at  = i;
                we_src = int'(src[1]);
            end
            if (bsy[1]) nb++;
            if (i == 6) busy6 = bsy[1];
            tick();
        end
        checks++;
        if (nds != 1 || ds_first != 1 || we_at != 5 || we_src != 1) begin
            failures++;
            $display("FAIL divu_short got start=%0d@%0d we@%0d src=%0d exp start=1@1 we@5 src=1", nds, ds_first, we_at, we_src);
        end
        checks++;
        if (nb != 5 || busy6 !== 1'b0) begin
            failures++;
            $display("FAIL divu_busy got cycles=%0d busy6=%b exp cycles=5 busy6=0", nb, busy6);
        end
    endtask

    task automatic test_mfhi_interlock();
        int         acc_at = 0;
        logic [1:0] sel_after = 2'bxx;
        op_valid = 1'b1;
        funct    = 6'd25;
        tick();
        funct    = 6'd16;
        for (int i = 1; i <= 36; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL mfhi_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
            if (acc_at != 0 && i == acc_at + 1) sel_after = sel[0];
            if (rdy[0] && acc_at == 0) acc_at = i;
            tick();
        end
        op_valid = 1'b0;
        tick();
        checks++;
        if (acc_at != 33 || sel_after !== 2'd2) begin
            failures++;
            $display("FAIL mfhi_interlock got accept@%0d sel=%0d exp accept@33 sel=2", acc_at, sel_after);
        end
    endtask

    task automatic test_reset_midrun();
        int   nwe = 0;
        logic rdy_rel;
        op_valid = 1'b1;
        funct    = 6'd25;
        tick();
        op_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (we !== 2'b00) nwe++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (observe(d) !== obs_t'(0)) begin
                failures++;
                $display("FAIL midrun_zero dut%0d got=%h exp=0", d, observe(d));
            end
        end
        tick();
        rst_n    = 1'b1;
        op_valid = 1'b1;
        funct    = 6'd32;
        #1;
        rdy_rel  = rdy[0];
        tick();
        op_valid = 1'b0;
        checks++;
        if (rdy_rel !== 1'b1 || ctrl[0] !== 6'd32) begin
            failures++;
            $display("FAIL midrun_restart got ready=%b ctrl=%0d exp ready=1 ctrl=32", rdy_rel, ctrl[0]);
        end
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL midrun_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
            if (we !== 2'b00) nwe++;
            tick();
        end
        checks++;
        if (nwe != 0) begin
            failures++;
            $display("FAIL midrun_no_we got=%0d exp=0", nwe);
        end
    endtask

    task automatic test_illegal();
        op_valid = 1'b1;
        funct    = 6'd7;
        tick();
        funct    = 6'd34;
        checks++;
        if (ill[0] !== 1'b1 || ctrl[0] !== 6'd0 || ms[0] !== 1'b0 || ds[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse got ill=%b ctrl=%0d ms=%b ds=%b busy=%b rdy=%b exp 1,0,0,0,0,1",
                     ill[0], ctrl[0], ms[0], ds[0], bsy[0], rdy[0]);
        end
        tick();
        op_valid = 1'b0;
        checks++;
        if (ill[0] !== 1'b0 || ctrl[0] !== 6'd34 || sel[0] !== 2'd0) begin
            failures++;
            $display("FAIL illegal_then_sub got ill=%b ctrl=%0d sel=%0d exp ill=0 ctrl=34 sel=0", ill[0], ctrl[0], sel[0]);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (observe(d) !== expect_of(d)) begin
                failures++;
                $display("FAIL illegal_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] pool [12] = '{6'd32, 6'd36, 6'd37, 6'd34, 6'd42, 6'd2,
                                  6'd16, 6'd18, 6'd25, 6'd27, 6'd7, 6'd63};
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            op_valid = ($urandom_range(0, 2) != 0);
            funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== expect_of(d)) begin
                    failures++;
                    $display("FAIL random_model dut%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d), expect_of(d));
                end
            end
        end
        rst_n    = 1'b1;
        op_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_multu();
        test_divu();
        test_mfhi_interlock();
        test_reset_midrun();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
